// File: rtl/rr_arb_mux.sv
//==============================================================================
// Module      : rr_arb_mux
// Description : N-way round-robin arbitrating mux, valid/ready on both sides,
//               registered output slot that holds its word until consumed.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             in_valid,
    input  logic [N*WIDTH-1:0]       in_data,
    output logic [N-1:0]             in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N)-1:0]     out_sel,
    input  logic                     out_ready
);

    localparam int SEL_W = $clog2(N);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(N - 1);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_found;
    logic             w_load;
    int               w_idx;
    logic [SEL_W-1:0] w_grant;
    logic [N-1:0]     w_grant_oh;
    logic [WIDTH-1:0] w_grant_data;

    // Scan channels starting at the priority pointer, wrapping modulo N;
    // the first requester seen wins. Index arithmetic stays below N, so
    // non-power-of-two N never produces an out-of-range grant.
    always_comb begin
        w_found      = 1'b0;
        w_idx        = 0;
        w_grant      = '0;
        w_grant_oh   = '0;
        w_grant_data = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_found && in_valid[w_idx]) begin
                w_found           = 1'b1;
                w_grant           = w_idx[SEL_W-1:0];
                w_grant_oh[w_idx] = 1'b1;
                w_grant_data      = in_data[w_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Slot can take a word when empty or being drained this same cycle.
    assign w_load   = ~rst & (~r_out_valid | out_ready) & (|in_valid);
    assign in_ready = w_load ? w_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant;
            r_ptr       <= (w_grant == c_last) ? '0 : w_grant + 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
//==============================================================================
// Module      : tb_rr_arb_mux
// Description : Directed self-checking bench for rr_arb_mux (N=4/W=32 and
//               N=3/W=8 builds).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_arb_mux;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic         b_rst;
    logic [2:0]   b_in_valid;
    logic [23:0]  b_in_data;
    logic [2:0]   b_in_ready;
    logic         b_out_valid;
    logic [7:0]   b_out_data;
    logic [1:0]   b_out_sel;
    logic         b_out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_ready(b_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_sel"},   64'(out_sel),   64'(s));
        check({tag, "_data"},  64'(out_data),  64'(d));
    endtask

    initial begin
        // Test 1: reset with every channel requesting
        rst         = 1'b1;
        in_valid    = 4'b1111;
        in_data     = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        out_ready   = 1'b1;
        b_rst       = 1'b1;
        b_in_valid  = 3'b111;
        b_in_data   = {8'h12, 8'h11, 8'h10};
        b_out_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'h0);
        step();
        check_out("rst_out", 1'b0, 2'd0, 32'h0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'h0);

        // Test 2: round robin, one word per cycle
        rst        = 1'b0;
        b_rst      = 1'b0;
        b_in_valid = 3'b000;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (i % 4)));
            step();
            check_out("rr_out", 1'b1, 2'(i % 4), 32'hA0 + 32'(i % 4));
        end

        // Test 3: backpressure on a held ch2 word
        in_data[64 +: 32] = 32'hCAFE;
        #1;
        check("bp_in_ready_load", 64'(in_ready), 64'b0100);
        step();
        check_out("bp_load", 1'b1, 2'd2, 32'hCAFE);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready_stall", 64'(in_ready), 64'h0);
            step();
            check_out("bp_hold", 1'b1, 2'd2, 32'hCAFE);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 64'(in_ready), 64'b1000);
        step();
        check_out("bp_next", 1'b1, 2'd3, 32'hA3);

        // Test 4: sparse requests and pointer skip (ptr now 0)
        in_valid = 4'b0001;
        step();
        check_out("sp_ch0_a", 1'b1, 2'd0, 32'hA0);
        #1;
        check("sp_single_in_ready", 64'(in_ready), 64'b0001);
        step();
        check_out("sp_ch0_b", 1'b1, 2'd0, 32'hA0);
        in_valid = 4'b1001;
        #1;
        check("sp_skip_in_ready", 64'(in_ready), 64'b1000);
        step();
        check_out("sp_ch3", 1'b1, 2'd3, 32'hA3);
        #1;
        check("sp_wrap_in_ready", 64'(in_ready), 64'b0001);
        step();
        check_out("sp_ch0_c", 1'b1, 2'd0, 32'hA0);
        in_valid = 4'b0000;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'h0);
        step();
        check_out("idle_drain", 1'b0, 2'd0, 32'hA0);

        // Test 5: reset while a word is held
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        step();
        check_out("mr_held", 1'b1, 2'd2, 32'hCAFE);
        rst = 1'b1;
        #1;
        check("mr_rst_in_ready", 64'(in_ready), 64'h0);
        step();
        check_out("mr_cleared", 1'b0, 2'd0, 32'h0);
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("mr_restart_in_ready", 64'(in_ready), 64'b0001);
        step();
        check_out("mr_restart", 1'b1, 2'd0, 32'hA0);

        // Test 6: N=3, WIDTH=8 build cycles 0,1,2 and never reaches 3
        b_in_valid = 3'b111;
        #1;
        for (int i = 0; i < 7; i++) begin
            check("n3_in_ready", 64'(b_in_ready), 64'(3'b001 << (i % 3)));
            step();
            check("n3_valid", 64'(b_out_valid), 64'h1);
            check("n3_sel",   64'(b_out_sel),   64'(i % 3));
            check("n3_data",  64'(b_out_data),  64'(8'h10 + 8'(i % 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
